// File: rtl/aes_sbox_scheduler_pkg.sv
// Shared types and constants for the AES S-box scheduler.
// Owner, FSM state and S-box direction encodings.
package aes_sbox_scheduler_pkg;

  localparam int DEF_WORD_BYTES = 4;

  localparam logic ENC = 1'b1;
  localparam logic DEC = 1'b0;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    RESP
  } state_t;

  typedef enum logic {
    KEY  = 1'b0,
    DATA = 1'b1
  } owner_t;

endpackage

// File: rtl/aes_sbox_scheduler_if.sv
// Requester, result and S-box signals of the scheduler.
// slave = scheduler side, master = environment side.
interface aes_sbox_scheduler_if;
  import aes_sbox_scheduler_pkg::*;

  localparam int W = 8 * DEF_WORD_BYTES;

  logic         key_req;
  logic [W-1:0] key_word;
  logic         key_done;
  logic         data_req;
  logic [W-1:0] data_word;
  logic         data_enc_dec;
  logic         data_done;
  logic [W-1:0] result_word;
  logic         busy;
  logic [7:0]   sbox_in;
  logic         sbox_enc_dec;
  logic [7:0]   sbox_out_enc;
  logic [7:0]   sbox_out_dec;

  modport slave (
    input  key_req, key_word,
    input  data_req, data_word, data_enc_dec,
    input  sbox_out_enc, sbox_out_dec,
    output key_done, data_done,
    output result_word, busy,
    output sbox_in, sbox_enc_dec
  );

  modport master (
    output key_req, key_word,
    output data_req, data_word, data_enc_dec,
    output sbox_out_enc, sbox_out_dec,
    input  key_done, data_done,
    input  result_word, busy,
    input  sbox_in, sbox_enc_dec
  );

endinterface

// File: rtl/aes_rr_arb2.sv
// Two-input round-robin arbiter (KEY vs DATA).
// Ties go to whichever requester was not granted last.
module aes_rr_arb2
  import aes_sbox_scheduler_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   en,
  input  logic   key_req,
  input  logic   data_req,
  output logic   gnt,
  output owner_t owner
);

  owner_t last_grant;

  always_comb begin
    gnt   = en & (key_req | data_req);
    owner = KEY;
    unique case (1'b1)
      key_req & data_req:
        owner = (last_grant == KEY) ? DATA : KEY;
      data_req & ~key_req:
        owner = DATA;
      default:
        owner = KEY;
    endcase
  end

  // Reset to DATA so the first tie is won by KEY.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= DATA;
    end else if (gnt) begin
      last_grant <= owner;
    end
  end

endmodule

// File: rtl/aes_sbox_scheduler.sv
// Shares one pipelined S-box between key schedule and round datapath.
// Serialises a word into bytes, substitutes, reassembles, pulses done.
module aes_sbox_scheduler
  import aes_sbox_scheduler_pkg::*;
#(
  parameter int WORD_BYTES   = DEF_WORD_BYTES,
  parameter int SBOX_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  aes_sbox_scheduler_if.slave  bus
);

  localparam int W  = 8 * WORD_BYTES;
  localparam int CW = $clog2(WORD_BYTES);
  localparam logic [CW-1:0] LAST = CW'(WORD_BYTES - 1);

  state_t        state;
  owner_t        owner_q;
  logic [CW-1:0] cnt;
  logic [W-1:0]  word_q;
  logic          mode_q;

  logic          gnt;
  owner_t        gnt_owner;
  logic [CW-1:0] cap_idx;
  logic [CW-1:0] nxt_idx;
  logic [7:0]    cap_byte;

  aes_rr_arb2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .en       (state == IDLE),
    .key_req  (bus.key_req),
    .data_req (bus.data_req),
    .gnt      (gnt),
    .owner    (gnt_owner)
  );

  assign cap_idx  = cnt - CW'(SBOX_LATENCY);
  assign nxt_idx  = cnt + CW'(1);
  assign cap_byte = mode_q ? bus.sbox_out_enc
                           : bus.sbox_out_dec;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      owner_q          <= DATA;
      cnt              <= '0;
      word_q           <= '0;
      mode_q           <= ENC;
      bus.sbox_in      <= 8'h00;
      bus.sbox_enc_dec <= ENC;
      bus.result_word  <= '0;
      bus.key_done     <= 1'b0;
      bus.data_done    <= 1'b0;
      bus.busy         <= 1'b0;
    end else begin
      bus.key_done  <= 1'b0;
      bus.data_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (gnt) begin
            // First byte goes out straight from the request port.
            if (gnt_owner == KEY) begin
              word_q           <= bus.key_word;
              mode_q           <= ENC;
              bus.sbox_in      <= bus.key_word[7:0];
              bus.sbox_enc_dec <= ENC;
            end else begin
              word_q           <= bus.data_word;
              mode_q           <= bus.data_enc_dec;
              bus.sbox_in      <= bus.data_word[7:0];
              bus.sbox_enc_dec <= bus.data_enc_dec;
            end
            owner_q  <= gnt_owner;
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (cnt >= CW'(SBOX_LATENCY)) begin
            bus.result_word[{cap_idx, 3'b000} +: 8] <= cap_byte;
          end
          if (cnt == LAST) begin
            state <= DRAIN;
          end else begin
            cnt         <= nxt_idx;
            bus.sbox_in <= word_q[{nxt_idx, 3'b000} +: 8];
          end
        end
        DRAIN: begin
          bus.result_word[{LAST, 3'b000} +: 8] <= cap_byte;
          bus.key_done  <= (owner_q == KEY);
          bus.data_done <= (owner_q == DATA);
          state         <= RESP;
        end
        RESP: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
